// File: rtl/little_mem_pkg.sv
// Shared types, constants and the address-legality helper for rvfi_mem_model.
package little_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } mem_state_e;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

    // Legal accesses are word aligned and fall inside the depth-word backing store.
    function automatic logic addr_ok(input logic [31:0] addr, input int unsigned depth);
        logic [33:0] limit;
        limit = {2'b00, depth} << 2;
        return (addr[1:0] == 2'b00) && ({2'b00, addr} < limit);
    endfunction

endpackage

// File: rtl/mem_byte_ram.sv
// DEPTH x 32 backing store with per-byte write enables and asynchronous read.
// Contents are deliberately not reset.
module mem_byte_ram #(
    parameter int unsigned DEPTH = 1024
) (
    input  logic                     clock,
    input  logic [3:0]               we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);

    logic [31:0] mem [DEPTH];

    // Byte-lane writes on the rising edge.
    always_ff @(posedge clock) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/rvfi_mem_model.sv
// Memory responder for the core's native mem_* bus: minimum latency, per-cycle stall,
// protocol/bus error flags and transaction counters.
// Optional feature: define MEM_FAIRNESS_EN to force a response once the wait counter
// reaches MAX_WAIT, bounding the latency even under a permanent stall.
module rvfi_mem_model
    import little_mem_pkg::*;
#(
    parameter int unsigned DEPTH    = 1024,
    parameter int unsigned MIN_WAIT = 0,
    parameter int unsigned MAX_WAIT = 3,
    parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    input  logic        stall,
    input  logic        trap,
    output logic        bus_err,
    output logic        proto_err,
    output logic [31:0] txn_count,
    output logic [31:0] fetch_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

    mem_state_e    state_q, state_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic          proto_err_q, proto_set;
    logic [31:0]   txn_q, fetch_q;
    logic          min_met;
    logic          access_err;
    logic [3:0]    ram_we;
    logic [31:0]   ram_rdata;

    // With no minimum wait the comparison would be constant, so skip it entirely.
    if (MIN_WAIT == 0) begin : g_no_min
        assign min_met = 1'b1;
    end else begin : g_min
        assign min_met = (wait_cnt_q >= CW'(MIN_WAIT));
    end

    // State and wait counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Next-state logic; a dropped request takes priority over any response.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        proto_set  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mem_valid && !trap) begin
                    state_d    = WAIT;
                    wait_cnt_d = '0;
                end
            end
            WAIT: begin
                if (wait_cnt_q != WAIT_MAX) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
                if (!mem_valid) begin
                    state_d   = IDLE;
                    proto_set = 1'b1;
                end else if (min_met && !stall) begin
                    state_d = RESP;
                end
`ifdef MEM_FAIRNESS_EN
                else if (wait_cnt_q == WAIT_MAX) begin
                    state_d = RESP;
                end
`endif
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Response outputs; address, data and strobe are consumed only in the RESP cycle.
    always_comb begin
        access_err = !addr_ok(mem_addr, DEPTH);
        mem_ready  = (state_q == RESP);
        bus_err    = mem_ready && access_err;
        ram_we     = 4'b0000;
        mem_rdata  = 32'h0;
        if (mem_ready) begin
            if (mem_wstrb != 4'b0000) begin
                if (!access_err) begin
                    ram_we = mem_wstrb;
                end
            end else begin
                mem_rdata = access_err ? ERR_DATA : ram_rdata;
            end
        end
    end

    // Completion counters and the sticky protocol error.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            txn_q       <= 32'h0;
            fetch_q     <= 32'h0;
            proto_err_q <= 1'b0;
        end else begin
            if (state_q == RESP) begin
                txn_q <= txn_q + 32'h1;
                if (mem_instr) begin
                    fetch_q <= fetch_q + 32'h1;
                end
            end
            if (proto_set) begin
                proto_err_q <= 1'b1;
            end
        end
    end

    assign txn_count   = txn_q;
    assign fetch_count = fetch_q;
    assign proto_err   = proto_err_q;

    mem_byte_ram #(
        .DEPTH(DEPTH)
    ) u_ram (
        .clock(clock),
        .we   (ram_we),
        .addr (mem_addr[2 +: AW]),
        .wdata(mem_wdata),
        .rdata(ram_rdata)
    );

endmodule

// File: tb/tb_rvfi_mem_model.sv
// Randomised bench for rvfi_mem_model against a word-array reference model.
// Honours MEM_FAIRNESS_EN the same way the design does.
module tb_rvfi_mem_model;

    localparam int unsigned DEPTH    = 64;
    localparam int unsigned MIN_WAIT = 0;
    localparam int unsigned MAX_WAIT = 3;
    localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

    logic        clock;
    logic        reset;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        stall;
    logic        trap;
    logic        bus_err;
    logic        proto_err;
    logic [31:0] txn_count;
    logic [31:0] fetch_count;

    rvfi_mem_model #(
        .DEPTH   (DEPTH),
        .MIN_WAIT(MIN_WAIT),
        .MAX_WAIT(MAX_WAIT),
        .ERR_DATA(ERR_DATA)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .mem_valid  (mem_valid),
        .mem_instr  (mem_instr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .stall      (stall),
        .trap       (trap),
        .bus_err    (bus_err),
        .proto_err  (proto_err),
        .txn_count  (txn_count),
        .fetch_count(fetch_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] ref_mem [DEPTH];
    int unsigned ref_txn = 0;
    int unsigned ref_fetch = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_ready"}, 32'(mem_ready), 32'h0);
        check_eq({tag, "_rdata"}, mem_rdata, 32'h0);
        check_eq({tag, "_bus_err"}, 32'(bus_err), 32'h0);
    endtask

    // One complete transaction. stall_mode: 0 none, 1 random, 2 held high (fairness only).
    // Called just after a falling edge with the bus idle.
    task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, input bit instr, input int stall_mode);
        bit          sp [16];
        int          j_first;
        int          exp_k;
        bit          err;
        logic [31:0] exp_rd;
        int          idx;

        for (int i = 0; i < 16; i++) begin
            if (stall_mode == 2) sp[i] = 1'b1;
            else if (stall_mode == 1) sp[i] = (i < 10) && ($urandom_range(0, 1) == 1);
            else sp[i] = 1'b0;
        end
        // First WAIT cycle whose stall is low decides the response cycle.
        j_first = 15;
        for (int j = 15; j >= 1; j--) begin
            if (!sp[j]) j_first = j;
        end
`ifdef MEM_FAIRNESS_EN
        if (j_first > 1 + int'(MAX_WAIT)) j_first = 1 + int'(MAX_WAIT);
`endif
        exp_k = j_first + 1;

        err = (addr % 4 != 0) || (longint'(addr) >= 4 * longint'(DEPTH));
        idx = int'(addr >> 2);
        if (wstrb != 4'b0000) exp_rd = 32'h0;
        else if (err) exp_rd = ERR_DATA;
        else exp_rd = ref_mem[idx];

        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = wstrb;
        mem_instr = instr;
        stall     = sp[0];
        for (int k = 1; k <= exp_k; k++) begin
            @(negedge clock);
            check_eq("ready_timing", 32'(mem_ready), 32'(k == exp_k));
            if (k == exp_k) begin
                check_eq("rdata", mem_rdata, exp_rd);
                check_eq("bus_err", 32'(bus_err), 32'(err));
            end
            if (k < 16) stall = sp[k];
        end
        mem_valid = 1'b0;
        stall     = 1'b0;

        if (!err) begin
            for (int l = 0; l < 4; l++) begin
                if (wstrb[l]) ref_mem[idx][8*l +: 8] = wdata[8*l +: 8];
            end
        end
        ref_txn++;
        if (instr) ref_fetch++;

        @(negedge clock);
        check_quiet("after_resp");
        check_eq("txn_count", txn_count, ref_txn);
        check_eq("fetch_count", fetch_count, ref_fetch);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] w;
        logic [3:0]  s;

        reset     = 1'b1;
        mem_valid = 1'b0;
        mem_instr = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        mem_wstrb = 4'h0;
        stall     = 1'b0;
        trap      = 1'b0;

        // Reset state.
        @(negedge clock);
        @(negedge clock);
        check_quiet("reset");
        check_eq("reset_proto_err", 32'(proto_err), 32'h0);
        check_eq("reset_txn", txn_count, 32'h0);
        check_eq("reset_fetch", fetch_count, 32'h0);
        reset = 1'b0;
        @(negedge clock);

        // Preload every word so the model knows the whole store.
        for (int i = 0; i < int'(DEPTH); i++) begin
            run_txn(32'(i * 4), $urandom, 4'hF, 1'b0, 0);
        end

        // Directed: preload/read, partial-lane write, error accesses.
        run_txn(32'h10, 32'hCAFEF00D, 4'hF, 1'b0, 0);
        run_txn(32'h10, 32'h0, 4'h0, 1'b1, 0);
        run_txn(32'h20, 32'hAABBCCDD, 4'hF, 1'b0, 0);
        run_txn(32'h20, 32'h11223344, 4'b0101, 1'b0, 0);
        run_txn(32'h20, 32'h0, 4'h0, 1'b0, 0);
        check_eq("lane_merge_model", ref_mem[8], 32'hAA22CC44);
        run_txn(32'h3, 32'h0, 4'h0, 1'b0, 0);
        run_txn(32'(4 * DEPTH), 32'h0, 4'h0, 1'b0, 0);
        run_txn(32'h4, 32'h55555555, 4'hF, 1'b0, 0);
        run_txn(32'h7, 32'h12345678, 4'hF, 1'b0, 0);
        run_txn(32'h4, 32'h0, 4'h0, 1'b0, 0);

        // Randomised traffic with random stalls.
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 3) != 0) a = 32'($urandom_range(0, DEPTH - 1) * 4);
            else a = $urandom;
            w = $urandom;
            s = ($urandom_range(0, 1) == 1) ? 4'(($urandom)) : 4'h0;
            run_txn(a, w, s, 1'($urandom_range(0, 1)), 1);
        end

        // Permanent stall.
`ifdef MEM_FAIRNESS_EN
        run_txn(32'h40, 32'h0, 4'h0, 1'b0, 2);
`else
        mem_valid = 1'b1;
        mem_addr  = 32'h40;
        mem_wstrb = 4'h0;
        mem_instr = 1'b0;
        stall     = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clock);
            check_eq("stall_hold_ready", 32'(mem_ready), 32'h0);
        end
        stall = 1'b0;
        @(negedge clock);
        check_eq("stall_release_ready", 32'(mem_ready), 32'h1);
        check_eq("stall_release_rdata", mem_rdata, ref_mem[16]);
        mem_valid = 1'b0;
        ref_txn++;
        @(negedge clock);
        check_eq("stall_txn_count", txn_count, ref_txn);
`endif

        // trap blocks acceptance in IDLE.
        trap      = 1'b1;
        mem_valid = 1'b1;
        mem_addr  = 32'h0;
        mem_wstrb = 4'h0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            check_eq("trap_idle_ready", 32'(mem_ready), 32'h0);
        end
        mem_valid = 1'b0;
        trap      = 1'b0;
        @(negedge clock);
        check_eq("trap_txn_count", txn_count, ref_txn);

        // trap raised mid-transaction does not abort it.
        mem_valid = 1'b1;
        mem_addr  = 32'h8;
        stall     = 1'b1;
        @(negedge clock);
        trap = 1'b1;
        @(negedge clock);
        check_eq("trap_mid_wait", 32'(mem_ready), 32'h0);
        stall = 1'b0;
        @(negedge clock);
        check_eq("trap_mid_ready", 32'(mem_ready), 32'h1);
        check_eq("trap_mid_rdata", mem_rdata, ref_mem[2]);
        mem_valid = 1'b0;
        trap      = 1'b0;
        ref_txn++;
        @(negedge clock);
        check_eq("trap_mid_txn", txn_count, ref_txn);

        // Dropped request sets the sticky protocol error.
        mem_valid = 1'b1;
        mem_addr  = 32'hC;
        stall     = 1'b1;
        @(negedge clock);
        @(negedge clock);
        mem_valid = 1'b0;
        stall     = 1'b0;
        @(negedge clock);
        check_eq("proto_set", 32'(proto_err), 32'h1);
        check_quiet("proto_idle");
        repeat (3) @(negedge clock);
        check_eq("proto_no_txn", txn_count, ref_txn);
        run_txn(32'hC, 32'h0, 4'h0, 1'b0, 0);
        check_eq("proto_sticky", 32'(proto_err), 32'h1);

        // Reset during the WAIT of a write: outputs clear at once, no write lands.
        mem_valid = 1'b1;
        mem_addr  = 32'h44;
        mem_wdata = ~ref_mem[17];
        mem_wstrb = 4'hF;
        stall     = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check_quiet("mid_reset");
        check_eq("mid_reset_proto", 32'(proto_err), 32'h0);
        check_eq("mid_reset_txn", txn_count, 32'h0);
        check_eq("mid_reset_fetch", fetch_count, 32'h0);
        @(negedge clock);
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
        stall     = 1'b0;
        reset     = 1'b0;
        ref_txn   = 0;
        ref_fetch = 0;
        @(negedge clock);
        run_txn(32'h44, 32'h0, 4'h0, 1'b1, 0);
        check_eq("post_reset_proto", 32'(proto_err), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
